// File: rtl/operand_fetch_pkg.sv
// Shared widths, index/word types and output-stage states for the operand fetch unit.
package operand_fetch_pkg;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {ST_EMPTY, ST_FULL} ofu_state_e;
endpackage

// File: rtl/operand_fetch_unit_scoreboard.sv
// Busy scoreboard: one bit per register awaiting writeback, hazard queries that see
// the same-cycle writeback, and a registered flag for writebacks to idle registers.
module reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  reg_idx_t         set_reg,
  input  logic             clr_en,
  input  reg_idx_t         clr_reg,
  input  reg_idx_t         q_rs1,
  input  reg_idx_t         q_rs2,
  input  reg_idx_t         q_rd,
  input  logic             q_rd_en,
  output logic [NREGS-1:0] busy,
  output logic             raw_hazard,
  output logic             waw_hazard,
  output logic             wb_spurious
);
  logic [NREGS-1:0] r_busy;
  logic             r_spur;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_clr_rs1, w_clr_rs2, w_clr_rd;

  // A writeback landing this cycle resolves the hazard on its register.
  assign w_clr_rs1  = clr_en && (clr_reg == q_rs1);
  assign w_clr_rs2  = clr_en && (clr_reg == q_rs2);
  assign w_clr_rd   = clr_en && (clr_reg == q_rd);
  assign raw_hazard = (r_busy[q_rs1] & ~w_clr_rs1) | (r_busy[q_rs2] & ~w_clr_rs2);
  assign waw_hazard = q_rd_en & r_busy[q_rd] & ~w_clr_rd;

  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_en) w_busy_nxt[clr_reg] = 1'b0;
    if (set_en) w_busy_nxt[set_reg] = 1'b1;   // set applied last so it wins
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_spur <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_spur <= clr_en & ~r_busy[clr_reg];
    end
  end

  assign busy        = r_busy;
  assign wb_spurious = r_spur;
endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch: reads both sources from the register file with writeback bypass,
// stalls on scoreboard hazards and holds operands in a 1-entry valid/ready register.
module operand_fetch_unit
  import operand_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  reg_idx_t         req_rs1,
  input  reg_idx_t         req_rs2,
  input  reg_idx_t         req_rd,
  input  logic             req_rd_en,
  output reg_idx_t         rf_read_reg1,
  output reg_idx_t         rf_read_reg2,
  input  word_t            rf_data_out1,
  input  word_t            rf_data_out2,
  output reg_idx_t         rf_write_reg,
  output word_t            rf_data_in,
  output logic             rf_write_enable,
  input  logic             wb_valid,
  input  reg_idx_t         wb_reg,
  input  word_t            wb_data,
  output logic             op_valid,
  input  logic             op_ready,
  output word_t            op_a,
  output word_t            op_b,
  output reg_idx_t         op_rd,
  output logic             op_rd_en,
  output logic [NREGS-1:0] busy,
  output logic             wb_spurious
);
  ofu_state_e r_state, w_state_nxt;
  word_t      r_op_a, r_op_b;
  reg_idx_t   r_op_rd;
  logic       r_op_rd_en;
  word_t      w_opa, w_opb;
  logic       w_raw, w_waw, w_accept, w_load;

  assign rf_read_reg1    = req_rs1;
  assign rf_read_reg2    = req_rs2;
  assign rf_write_reg    = wb_reg;
  assign rf_data_in      = wb_data;
  assign rf_write_enable = wb_valid & rst_n;

  // The file only commits the writeback at the edge, so forward it here.
  assign w_opa = (wb_valid && wb_reg == req_rs1) ? wb_data : rf_data_out1;
  assign w_opb = (wb_valid && wb_reg == req_rs2) ? wb_data : rf_data_out2;

  assign req_ready = ((r_state == ST_EMPTY) | op_ready) & ~w_raw & ~w_waw;
  assign w_accept  = req_valid & req_ready;

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (w_accept & req_rd_en),
    .set_reg    (req_rd),
    .clr_en     (wb_valid),
    .clr_reg    (wb_reg),
    .q_rs1      (req_rs1),
    .q_rs2      (req_rs2),
    .q_rd       (req_rd),
    .q_rd_en    (req_rd_en),
    .busy       (busy),
    .raw_hazard (w_raw),
    .waw_hazard (w_waw),
    .wb_spurious(wb_spurious)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_EMPTY: if (w_accept) begin
        w_state_nxt = ST_FULL;
        w_load      = 1'b1;
      end
      ST_FULL: begin
        if (w_accept) begin
          w_load = 1'b1;
        end else if (op_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_rd    <= '0;
      r_op_rd_en <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_op_a     <= w_opa;
        r_op_b     <= w_opb;
        r_op_rd    <= req_rd;
        r_op_rd_en <= req_rd_en;
      end
    end
  end

  assign op_valid = (r_state == ST_FULL);
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign op_rd    = r_op_rd;
  assign op_rd_en = r_op_rd_en;
endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: behavioural register file, directed scenarios and a
// randomized phase checked against a queue of expected operands plus a scoreboard model.
module tb_operand_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_rd_en;
  logic [2:0]  req_rs1, req_rs2, req_rd;
  logic [2:0]  rf_read_reg1, rf_read_reg2, rf_write_reg;
  logic [18:0] rf_data_out1, rf_data_out2, rf_data_in;
  logic        rf_write_enable;
  logic        wb_valid;
  logic [2:0]  wb_reg;
  logic [18:0] wb_data;
  logic        op_valid, op_ready, op_rd_en;
  logic [18:0] op_a, op_b;
  logic [2:0]  op_rd;
  logic [7:0]  busy;
  logic        wb_spurious;

  typedef struct {
    logic [18:0] a;
    logic [18:0] b;
    logic [2:0]  rd;
    logic        rd_en;
  } exp_t;

  exp_t        exp_q[$];
  logic [18:0] rf[8];
  logic [7:0]  m_busy;
  logic        m_spur, m_valid;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  operand_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_rd_en(req_rd_en),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2),
    .rf_write_reg(rf_write_reg), .rf_data_in(rf_data_in), .rf_write_enable(rf_write_enable),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_rd_en(op_rd_en),
    .busy(busy), .wb_spurious(wb_spurious)
  );

  assign rf_data_out1 = rf[rf_read_reg1];
  assign rf_data_out2 = rf[rf_read_reg2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register file behaviour: writes commit on the edge from the DUT's write port.
  always @(posedge clk) begin
    if (rf_write_enable) rf[rf_write_reg] <= rf_data_in;
  end

  // Reference model evaluated on pre-edge values each cycle.
  always @(posedge clk) begin
    logic       raw, waw, exp_ready, acc;
    logic [7:0] nb;
    exp_t       e;
    if (!rst_n) begin
      m_busy  = '0;
      m_spur  = 1'b0;
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      chk("busy", {24'd0, busy}, {24'd0, m_busy});
      chk("wb_spurious", {31'd0, wb_spurious}, {31'd0, m_spur});
      chk("op_valid", {31'd0, op_valid}, {31'd0, m_valid});
      raw = (m_busy[req_rs1] && !(wb_valid && wb_reg == req_rs1)) ||
            (m_busy[req_rs2] && !(wb_valid && wb_reg == req_rs2));
      waw = req_rd_en && m_busy[req_rd] && !(wb_valid && wb_reg == req_rd);
      exp_ready = (!m_valid || op_ready) && !raw && !waw;
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      acc = req_valid && exp_ready;
      if (op_valid && op_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_op", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_op_a", {13'd0, op_a}, {13'd0, e.a});
          chk("sb_op_b", {13'd0, op_b}, {13'd0, e.b});
          chk("sb_op_rd", {29'd0, op_rd}, {29'd0, e.rd});
          chk("sb_op_rd_en", {31'd0, op_rd_en}, {31'd0, e.rd_en});
        end
      end
      if (acc) begin
        e.a     = (wb_valid && wb_reg == req_rs1) ? wb_data : rf[req_rs1];
        e.b     = (wb_valid && wb_reg == req_rs2) ? wb_data : rf[req_rs2];
        e.rd    = req_rd;
        e.rd_en = req_rd_en;
        exp_q.push_back(e);
      end
      m_spur = wb_valid && !m_busy[wb_reg];
      nb = m_busy;
      if (wb_valid) nb[wb_reg] = 1'b0;
      if (acc && req_rd_en) nb[req_rd] = 1'b1;
      m_busy  = nb;
      m_valid = acc || (m_valid && !op_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                     input logic en);
    req_valid = 1'b1;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_rd    = rd;
    req_rd_en = en;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = '0;
    rst_n = 1'b0; op_ready = 1'b1;
    req(3'd0, 3'd0, 3'd1, 1'b1);
    wb_valid = 1'b1; wb_reg = 3'd4; wb_data = 19'h11111;
    #2;
    chk("rst_rf_we", {31'd0, rf_write_enable}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
      chk("rst_busy", {24'd0, busy}, 32'h00);
      chk("rst_rf_we", {31'd0, rf_write_enable}, 32'd0);
    end
    chk("rst_no_write", {13'd0, rf[4]}, 32'd0);

    // Preload r1, r2 through the write port.
    rst_n = 1'b1; req_valid = 1'b0;
    wb_valid = 1'b1; wb_reg = 3'd1; wb_data = 19'h12345;
    tick();
    wb_reg = 3'd2; wb_data = 19'h00007;
    tick();
    wb_valid = 1'b0;

    // Basic read
    req(3'd1, 3'd2, 3'd3, 1'b1);
    #1 chk("basic_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("basic_op_valid", {31'd0, op_valid}, 32'd1);
    chk("basic_op_a", {13'd0, op_a}, 32'h12345);
    chk("basic_op_b", {13'd0, op_b}, 32'h00007);
    chk("basic_op_rd", {29'd0, op_rd}, 32'd3);
    chk("basic_busy", {24'd0, busy}, 32'h08);

    // RAW stall, then bypass
    req(3'd3, 3'd0, 3'd4, 1'b0);
    #1 chk("raw_stall", {31'd0, req_ready}, 32'd0);
    tick();
    chk("raw_op_valid", {31'd0, op_valid}, 32'd0);
    wb_valid = 1'b1; wb_reg = 3'd3; wb_data = 19'h7FFFF;
    #1 chk("raw_bypass_ready", {31'd0, req_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    chk("raw_op_a", {13'd0, op_a}, 32'h7FFFF);
    chk("raw_busy", {24'd0, busy}, 32'h00);

    // Backpressure then back-to-back
    op_ready = 1'b0;
    req(3'd1, 3'd2, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_op_valid", {31'd0, op_valid}, 32'd1);
      chk("bp_op_a", {13'd0, op_a}, 32'h7FFFF);
      chk("bp_op_rd", {29'd0, op_rd}, 32'd4);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    op_ready = 1'b1;
    #1 chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("b2b_op_valid", {31'd0, op_valid}, 32'd1);
    chk("b2b_op_a", {13'd0, op_a}, 32'h12345);
    chk("b2b_op_b", {13'd0, op_b}, 32'h00007);
    req_valid = 1'b0;
    tick();

    // WAW stall and set-wins
    req(3'd0, 3'd0, 3'd5, 1'b1);
    tick();
    chk("waw_busy_set", {24'd0, busy}, 32'h20);
    #1 chk("waw_stall", {31'd0, req_ready}, 32'd0);
    tick();
    chk("waw_op_valid", {31'd0, op_valid}, 32'd0);
    wb_valid = 1'b1; wb_reg = 3'd5; wb_data = 19'h05555;
    #1 chk("waw_wb_ready", {31'd0, req_ready}, 32'd1);
    tick();
    wb_valid = 1'b0; req_valid = 1'b0;
    chk("waw_set_wins", {24'd0, busy}, 32'h20);
    chk("waw_accepted", {31'd0, op_valid}, 32'd1);

    // Spurious writeback
    wb_valid = 1'b1; wb_reg = 3'd6; wb_data = 19'h3ABCD;
    tick();
    wb_valid = 1'b0;
    chk("spur_pulse", {31'd0, wb_spurious}, 32'd1);
    chk("spur_busy", {24'd0, busy}, 32'h20);
    op_ready = 1'b0;
    req(3'd6, 3'd6, 3'd0, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("spur_pulse_end", {31'd0, wb_spurious}, 32'd0);
    chk("spur_r6_a", {13'd0, op_a}, 32'h3ABCD);
    chk("spur_r6_b", {13'd0, op_b}, 32'h3ABCD);

    // Reset while FULL
    rst_n = 1'b0;
    tick();
    chk("mid_rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("mid_rst_busy", {24'd0, busy}, 32'h00);
    chk("mid_rst_op_a", {13'd0, op_a}, 32'd0);
    rst_n = 1'b1; op_ready = 1'b1;
    tick();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(3) != 0);
      req_rs1   = 3'($urandom_range(7));
      req_rs2   = 3'($urandom_range(7));
      req_rd    = 3'($urandom_range(7));
      req_rd_en = ($urandom_range(1) != 0);
      wb_valid  = ($urandom_range(1) != 0);
      wb_reg    = 3'($urandom_range(7));
      wb_data   = 19'($urandom);
      op_ready  = ($urandom_range(3) != 0);
      tick();
    end
    req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
    repeat (3) tick();
    chk("drain_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
